// File: rtl/dgcl_pkg.sv
// Shared types and constants for the DGCL TSN-DMA channel responder.
package dgcl_pkg;

  localparam logic [7:0]  CMD_WRITE  = 8'h03;
  localparam logic [7:0]  CMD_READ   = 8'h01;
  localparam int unsigned BEAT_BYTES = 16;

  // 128-bit command header as carried on the first DMA write beat.
  typedef struct packed {
    logic [47:0] rsvd;
    logic [7:0]  cmd;
    logic [15:0] len;
    logic [39:0] dram_addr;
    logic [15:0] dpram_addr;
  } dgcl_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WR_DATA,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_DONE
  } dgcl_state_t;

endpackage

// File: rtl/dgcl_beat_reg.sv
// One-entry valid/ready output register; accepts a new beat on the same edge
// the held one drains, so a stream passes at one beat per cycle.
module dgcl_beat_reg #(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  // Load on accept, otherwise clear valid once the consumer takes the beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dgcl_dma_responder.sv
// Single-channel TSN-DMA responder: grants a request, decodes one header beat
// and either forwards payload as write-control beats or issues one read-control
// command and streams the returned data back to the initiator.
module dgcl_dma_responder
  import dgcl_pkg::*;
#(
  parameter int unsigned DW         = 128,
  parameter int unsigned BEAT_BYTES = dgcl_pkg::BEAT_BYTES
) (
  input  logic          fpu_clk,
  input  logic          reset_n,
  input  logic          dma_req,
  output logic          dma_resp,
  input  logic          dma_write_valid,
  input  logic [DW-1:0] dma_write_data,
  output logic          dma_write_ready,
  output logic          dma_read_valid,
  output logic [DW-1:0] dma_read_data,
  input  logic          dma_read_ready,
  output logic          wcc_valid,
  input  logic          wcc_ready,
  output logic [39:0]   wcc_dram_addr,
  output logic [15:0]   wcc_dpram_addr,
  output logic [15:0]   wcc_length,
  output logic [DW-1:0] wcc_write_data,
  output logic          rcc_valid,
  input  logic          rcc_ready,
  output logic [39:0]   rcc_dram_addr,
  output logic [15:0]   rcc_dpram_addr,
  output logic [15:0]   rcc_length,
  input  logic          rcd_valid,
  input  logic [DW-1:0] rcd_read_data,
  output logic          rcd_ready,
  output logic          busy,
  output logic          err_cmd
);

  localparam int unsigned WCC_W = 72 + DW;

  dgcl_state_t state;
  dgcl_hdr_t   beat;
  logic [15:0] len_q;
  logic [15:0] beat_cnt;
  logic [39:0] dram_q;
  logic [15:0] dpram_q;

  logic             wcc_in_valid, wcc_in_ready, wr_fire;
  logic [WCC_W-1:0] wcc_in, wcc_out;
  logic             rd_in_valid, rd_in_ready, rd_more, rcd_fire;

  // Typed view of the incoming write beat; the full beat is also the payload.
  assign beat = dma_write_data;

  // Write path: dram_q/dpram_q run ahead per accepted beat, wrapping naturally.
  assign wcc_in_valid    = (state == ST_WR_DATA) && dma_write_valid;
  assign wcc_in          = {dram_q, dpram_q, len_q, beat};
  assign wr_fire         = wcc_in_valid && wcc_in_ready;
  assign dma_write_ready = (state == ST_HDR) || ((state == ST_WR_DATA) && wcc_in_ready);

  dgcl_beat_reg #(.W(WCC_W)) u_wcc_reg (
    .clk      (fpu_clk),
    .reset_n  (reset_n),
    .in_valid (wcc_in_valid),
    .in_data  (wcc_in),
    .in_ready (wcc_in_ready),
    .out_valid(wcc_valid),
    .out_data (wcc_out),
    .out_ready(wcc_ready)
  );

  assign {wcc_dram_addr, wcc_dpram_addr, wcc_length, wcc_write_data} = wcc_out;

  // Read path: stop taking rcd beats once L have been accepted.
  assign rd_more     = (beat_cnt != len_q);
  assign rd_in_valid = (state == ST_RD_DATA) && rcd_valid && rd_more;
  assign rcd_ready   = (state == ST_RD_DATA) && rd_more && rd_in_ready;
  assign rcd_fire    = rd_in_valid && rd_in_ready;

  dgcl_beat_reg #(.W(DW)) u_rd_reg (
    .clk      (fpu_clk),
    .reset_n  (reset_n),
    .in_valid (rd_in_valid),
    .in_data  (rcd_read_data),
    .in_ready (rd_in_ready),
    .out_valid(dma_read_valid),
    .out_data (dma_read_data),
    .out_ready(dma_read_ready)
  );

  assign rcc_dram_addr  = dram_q;
  assign rcc_dpram_addr = dpram_q;
  assign rcc_length     = len_q;
  assign busy           = (state != ST_IDLE);

  // Transfer sequencing with registered grant, error and read-command outputs.
  always_ff @(posedge fpu_clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      dma_resp  <= 1'b0;
      err_cmd   <= 1'b0;
      rcc_valid <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      dram_q    <= '0;
      dpram_q   <= '0;
    end else begin
      dma_resp <= 1'b0;
      err_cmd  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dma_req) begin
            dma_resp <= 1'b1;
            state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (dma_write_valid) begin
            len_q    <= beat.len;
            dram_q   <= beat.dram_addr;
            dpram_q  <= beat.dpram_addr;
            beat_cnt <= '0;
            if (beat.cmd != CMD_WRITE && beat.cmd != CMD_READ) begin
              err_cmd <= 1'b1;
              state   <= ST_DONE;
            end else if (beat.len == 16'd0) begin
              state <= ST_DONE;
            end else if (beat.cmd == CMD_WRITE) begin
              state <= ST_WR_DATA;
            end else begin
              rcc_valid <= 1'b1;
              state     <= ST_RD_CMD;
            end
          end
        end
        ST_WR_DATA: begin
          if (wr_fire) begin
            beat_cnt <= beat_cnt + 16'd1;
            dram_q   <= dram_q + 40'(BEAT_BYTES);
            dpram_q  <= dpram_q + 16'd1;
            if (beat_cnt == len_q - 16'd1) state <= ST_DONE;
          end
        end
        ST_RD_CMD: begin
          if (rcc_ready) begin
            rcc_valid <= 1'b0;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rcd_fire) beat_cnt <= beat_cnt + 16'd1;
          if (!rd_more && !dma_read_valid) state <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dgcl_dma_responder.md
# dgcl_dma_responder

Single-channel responder for the TSN-DMA port protocol that FPU-side initiators drive (`dma_req`/`dma_resp`, `dma_write_*`, `dma_read_*`). It grants a request, then accepts one 128-bit header beat and decodes its command:
- **WRITE:** forwards the payload beats as write-control commands toward the RISC/DRAM side.
- **READ:** issues one read-control command and streams the returned data back on the DMA read channel.

One instance serves one channel (A–D) inside the gather/scatter layer.

## Interface
Parameters:
- `DW`, 128, beat width. Header layout is fixed for 128.
- `BEAT_BYTES`, 16, DRAM address increment per beat.

Ports:
- `fpu_clk` in 1: the single clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `dma_req` in 1: initiator request, held high until `dma_resp` is seen.
- `dma_resp` out 1: one-cycle grant pulse.
- `dma_write_valid` in 1, `dma_write_data` in DW, `dma_write_ready` out 1: header and payload from initiator.
- `dma_read_valid` out 1, `dma_read_data` out DW, `dma_read_ready` in 1: read data to initiator.
- `wcc_valid` out 1, `wcc_ready` in 1, `wcc_dram_addr` out 40, `wcc_dpram_addr` out 16, `wcc_length` out 16, `wcc_write_data` out DW: write-control command per beat.
- `rcc_valid` out 1, `rcc_ready` in 1, `rcc_dram_addr` out 40, `rcc_dpram_addr` out 16, `rcc_length` out 16: read-control command.
- `rcd_valid` in 1, `rcd_read_data` in DW, `rcd_ready` out 1: read data from RISC side. `rcd_dpram_addr` and `rcd_length` are not used.
- `busy` out 1: the state is not IDLE.
- `err_cmd` out 1: one-cycle pulse when an unknown command header is consumed.

## Operation
Header fields:
- `[127:80]` are reserved and ignored.
- `[79:72]` is the command: 0x03 = WRITE, 0x01 = READ.
- `[71:56]` is the length L in beats.
- `[55:16]` is the 40-bit DRAM address.
- `[15:0]` is the DPRAM address; `[15:14]` selects the channel bank.

State machine:
- **IDLE:** when `dma_req` is sampled high, pulse `dma_resp` for one cycle and go to HDR.
- **HDR:** `dma_write_ready` is 1. On a header beat:
  - WRITE with L>0 → WR_DATA.
  - READ with L>0 → RD_CMD.
  - L==0 for either command → DONE, with no wcc/rcc issued.
  - Any other command → pulse `err_cmd` and go to DONE.
- **WR_DATA:** beat k (0..L−1) loads the wcc output register:
  - `wcc_dram_addr` = base + k·BEAT_BYTES, modulo 2^40.
  - `wcc_dpram_addr` = base + k, modulo 2^16, so 0xFFFF wraps to 0x0000.
  - `wcc_length` = L and `wcc_write_data` = the beat.
  - After beat L−1 is accepted → DONE.
  - `dma_write_ready` = `!wcc_valid || wcc_ready`.
- **RD_CMD:** hold `rcc_valid` with the header fields until `rcc_ready` → RD_DATA.
- **RD_DATA:**
  - Each rcd beat loads the read output register; `rcd_ready` = `!dma_read_valid || dma_read_ready`.
  - After L beats have been accepted from rcd and the output register has drained → DONE.
- **DONE:** one cycle, then IDLE. Any `dma_write_valid` outside HDR/WR_DATA is not acknowledged: `dma_write_ready` is 0.

## Timing
- Every output resets to 0 and the state resets to IDLE. Reset mid-transfer discards the registered beats and counters at that edge.
- `dma_req` is sampled high at edge t. `dma_resp` and `dma_write_ready` are high in cycle t+1. `dma_resp` is low again from t+2.
- A header accepted at edge h produces the first `wcc_valid` at h+1 at the earliest; each wcc beat appears 1 cycle after its DMA acceptance.
- WRITE throughput is 1 beat/cycle while `wcc_ready`=1. With `wcc_ready` low, exactly one beat is held and `dma_write_ready` drops combinationally. No loss or duplication.
- READ: `rcc_valid` rises 1 cycle after header acceptance. Data has 1-cycle latency from rcd to dma_read, at 1 beat/cycle when unstalled.
- When an output register is drained and refilled on the same edge, new data is registered and valid stays high.
- `dma_req` high while not in IDLE is ignored until the state returns to IDLE.

## Structure
- Shared package `dgcl_pkg`:
  - command constants `CMD_WRITE`=8'h03 and `CMD_READ`=8'h01;
  - packed header struct `dgcl_hdr_t`;
  - state enum;
  - `BEAT_BYTES`.
- One sub-module, `dgcl_beat_reg`: a one-entry valid/ready register. It is used twice: for the wcc beat path and for the dma_read output path.

## Test plan
1. WRITE, L=4, DRAM 0x10_0000_0000, DPRAM 0x4000 → four wcc beats:
   - DRAM addresses 0x10_0000_0000/…010/…020/…030;
   - DPRAM addresses 0x4000–0x4003;
   - `wcc_length`=4; data identical and in order.
2. WRITE, L=16, with `wcc_ready` low for 3 cycles after beat 5 → `dma_write_ready` is low in those cycles; exactly 16 wcc beats; no gap or duplication.
3. READ, L=2, DRAM 0x0_0000_0100, DPRAM 0x8000 → one rcc command with `rcc_length`=2; rcd beats D0 and D1 appear on dma_read in order while `dma_read_ready` alternates 1,0,1.
4. Boundary cases:
   - READ header with L=0 (cmd 0x01, DPRAM 0x4000) → no rcc; `busy` falls 2 cycles after the header.
   - WRITE with DPRAM 0xFFFE and L=3 → DPRAM addresses 0xFFFE, 0xFFFF, 0x0000.
5. Header with command 0x7F → `err_cmd` high for exactly 1 cycle; no wcc/rcc; the next `dma_req` is granted normally.
6. `reset_n`=0 after beat 2 of an L=8 WRITE → every output is 0 at the next edge. A following L=1 WRITE completes correctly.
